dz_count_ctrl: RTL and testbench
================================

Name: dz_count_ctrl

Overview:
Controller that sequences the 8x8 red/green dot-matrix digit display for the countdown function. It generates the row-scan timing and the one-hot row select. It runs the START_NUM..0 countdown with start and pause control, and supplies the current digit and row index to the glyph stage. It sits between the board buttons (already debounced to one-cycle pulses) and the glyph/colour datapath, which registers its outputs once.

Parameters:
SCAN_DIV, 1000, clk cycles per row dwell; legal range >= 1.
TICK_DIV, 1000000, clk cycles per countdown step; legal range >= 2.
START_NUM, 5, first digit shown after start; legal range 1..7 (3-bit).

Ports:
clk  in  1  system clock, the only clock.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse: begin or restart the countdown.
pause  in  1  one-cycle pulse: toggle between COUNT and PAUSE.
num  out  3  digit currently selected for display; 0 = blank/finished.
row_count  out  3  row index 0..7 presented to the glyph stage.
row  out  8  active-low one-hot row select, ~(1<<row_count), delayed 1 clk.
busy  out  1  high in COUNT or PAUSE.
done  out  1  one-cycle pulse when the count reaches 0.

Behaviour:
- Reset is synchronous: all state is sampled on posedge clk when rst=1. Reset values:
  - state=IDLE, num=0, row_count=0, row=8'hFF, busy=0, done=0.
  - scan_cnt=0, tick_cnt=0.
- Row scan runs in every state while rst=0:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - At the terminal value, row_count increments, wrapping 7->0.
  - With SCAN_DIV=1, row_count advances every cycle.
- row is registered from row_count, so it lags row_count by exactly 1 clk. This aligns it with the glyph stage's registered colr/colg.
- FSM states are IDLE, COUNT and PAUSE. busy = (state != IDLE), registered together with the state.
- IDLE:
  - num=0.
  - start -> COUNT; num<=START_NUM and tick_cnt<=0 in the same edge.
- COUNT:
  - tick_cnt increments each cycle.
  - At TICK_DIV-1, tick_cnt<=0 and:
    - if num==1: num<=0, state<=IDLE, done<=1 for that one cycle;
    - otherwise num<=num-1.
  - pause -> PAUSE.
- PAUSE:
  - tick_cnt and num hold; the row scan continues, so the display stays lit.
  - pause -> COUNT, resuming from the held tick_cnt.
- Start priority:
  - start in COUNT or PAUSE restarts: num<=START_NUM, tick_cnt<=0, state<=COUNT.
  - start and pause in the same cycle: start wins and pause is ignored.
- Tick terminal and pause in the same cycle: the decrement or done is applied first. The state goes to PAUSE with tick_cnt=0, unless num was 1, in which case the state goes to IDLE.
- Tick terminal and start in the same cycle: the restart wins; no decrement and no done.
- Reset asserted mid-count: returns to the reset values on the next edge. done is not pulsed.
- Widths:
  - scan_cnt is $clog2(SCAN_DIV) bits, min 1.
  - tick_cnt is $clog2(TICK_DIV) bits.
  - num arithmetic is 3-bit unsigned; it never underflows because 0 is reached only via the num==1 path.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package dz_pkg holds:
  - the state enum (IDLE/COUNT/PAUSE);
  - DZ_ROWS=8;
  - the ROW_ACTIVE_LOW polarity constant;
  - the default START_NUM.
- One natural sub-module, dz_row_scan: the scan divider, the row_count counter and the registered active-low row decode, parameterised by SCAN_DIV.
- The FSM and tick divider stay in dz_count_ctrl.

Test Plan:
(Bench parameters: SCAN_DIV=2, TICK_DIV=10, START_NUM=5.)
1. Hold rst for 3 cycles, then release.
   -> During reset: row=8'hFF, num=0, busy=0.
   -> After release: row_count steps 0,1,2... every 2 clk, wrapping 7->0.
   -> row=8'hFE one clk after row_count=0, and 8'hFD one clk after row_count=1.
2. start pulse at cycle t.
   -> num=5 and busy=1 at t+1; num=4 at t+11, 3 at t+21, ..., 1 at t+41.
   -> num=0, done=1 (only that cycle) and busy=0 at t+51.
3. pause 3 cycles after num becomes 5, wait 20 cycles, then pause again.
   -> num holds 5 throughout the pause.
   -> num=4 exactly 7 cycles after the resuming pause; rows keep scanning during the pause.
4. start and pause asserted together in IDLE.
   -> state=COUNT (busy=1, num=5), not PAUSE; the next tick occurs 10 cycles later.
5. start pulse while in COUNT with num=2.
   -> num=5 on the next cycle; num=4 exactly 10 cycles later; no done pulse.
6. rst pulse while num=3 in COUNT.
   -> Next cycle: num=0, busy=0, row=8'hFF, row_count=0, done never asserted.

Source files
------------

// File: rtl/dz_pkg.sv
// Shared types and constants for the countdown dot-matrix controller.
// Holds the FSM state enum, row count, row polarity and default start digit.
package dz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_PAUSE = 2'd2
  } dz_state_e;

  localparam int DZ_ROWS        = 8;
  localparam bit ROW_ACTIVE_LOW = 1'b1;
  localparam int DZ_START_NUM   = 5;

endpackage

// File: rtl/dz_row_scan.sv
// Row scan: dwell divider, 0..7 row index and registered row decode.
// Ports: clk, rst (sync, high) in; row_count[2:0], row[7:0] out.
module dz_row_scan
  import dz_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic         clk,
  input  logic         rst,
  output logic [2:0]   row_count,
  output logic [DZ_ROWS-1:0] row
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DZ_ROWS-1:0] ROW_OFF =
    ROW_ACTIVE_LOW ? '1 : '0;

  logic [SW-1:0]      scan_cnt_q, scan_cnt_d;
  logic [2:0]         row_count_q, row_count_d;
  logic [DZ_ROWS-1:0] row_q, row_d;
  logic [DZ_ROWS-1:0] onehot;
  logic               scan_last;

  always_comb begin
    scan_last   = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d  = scan_last ? '0 : scan_cnt_q + SW'(1);
    row_count_d = scan_last ? row_count_q + 3'd1
                            : row_count_q;
    // decode the current index so row trails row_count by one clk
    onehot = DZ_ROWS'(1) << row_count_q;
    row_d  = ROW_ACTIVE_LOW ? ~onehot : onehot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      row_count_q <= '0;
      row_q       <= ROW_OFF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      row_count_q <= row_count_d;
      row_q       <= row_d;
    end
  end

  assign row_count = row_count_q;
  assign row       = row_q;

endmodule

// File: rtl/dz_count_ctrl.sv
// Countdown controller: START_NUM..0 FSM with start/pause plus row scan.
// Ports: clk, rst, start, pause in; num, row_count, row, busy, done out.
module dz_count_ctrl
  import dz_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int TICK_DIV  = 1000000,
  parameter int START_NUM = DZ_START_NUM
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  output logic [2:0] num,
  output logic [2:0] row_count,
  output logic [7:0] row,
  output logic       busy,
  output logic       done
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [2:0]    START_V   = 3'(START_NUM);

  dz_state_e     state_q, state_d;
  logic [2:0]    num_q, num_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tick_last;

  dz_row_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .row_count (row_count),
    .row       (row)
  );

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    tick_d    = tick_q;
    done_d    = 1'b0;
    tick_last = (tick_q == TICK_LAST);
    if (start) begin
      // restart from any state; overrides pause and a same-cycle tick
      state_d = ST_COUNT;
      num_d   = START_V;
      tick_d  = '0;
    end else begin
      case (state_q)
        ST_COUNT: begin
          if (tick_last) begin
            tick_d = '0;
            if (num_q == 3'd1) begin
              num_d   = 3'd0;
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              num_d = num_q - 3'd1;
              if (pause) state_d = ST_PAUSE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
            if (pause) state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (pause) state_d = ST_COUNT;
        end
        default: begin
          state_d = ST_IDLE;
          num_d   = 3'd0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      tick_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign num  = num_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_dz_count_ctrl.sv
// Bench for dz_count_ctrl: per-cycle scoreboard against a reference model
// plus a vector table of absolute checkpoints for the countdown scenarios.
module tb_dz_count_ctrl;

  localparam int SCAN_DIV  = 2;
  localparam int TICK_DIV  = 10;
  localparam int START_NUM = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] num;
  logic [2:0] row_count;
  logic [7:0] row;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  dz_count_ctrl #(
    .SCAN_DIV  (SCAN_DIV),
    .TICK_DIV  (TICK_DIV),
    .START_NUM (START_NUM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .num       (num),
    .row_count (row_count),
    .row       (row),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] num;
    logic [2:0] rc;
    logic [7:0] row;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    bit         r;
    bit         s;
    bit         p;
    int         idle;
    logic [2:0] num;
    logic       busy;
    logic       done;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];

  int         m_st, m_num, m_tick, m_scan, m_rc;
  logic [7:0] m_row;
  bit         m_busy, m_done;

  task automatic model_step(input bit r, input bit s, input bit p);
    logic [7:0] one;
    one = 8'h01;
    if (r) begin
      m_st = 0; m_num = 0; m_tick = 0;
      m_scan = 0; m_rc = 0; m_row = 8'hFF;
      m_busy = 0; m_done = 0;
    end else begin
      m_row = ~(one << m_rc);
      if (m_scan == SCAN_DIV - 1) begin
        m_scan = 0;
        m_rc = (m_rc + 1) % 8;
      end else begin
        m_scan++;
      end
      m_done = 0;
      if (s) begin
        m_st = 1; m_num = START_NUM; m_tick = 0;
      end else if (m_st == 1) begin
        if (m_tick == TICK_DIV - 1) begin
          m_tick = 0;
          if (m_num == 1) begin
            m_num = 0; m_st = 0; m_done = 1;
          end else begin
            m_num--;
            if (p) m_st = 2;
          end
        end else begin
          m_tick++;
          if (p) m_st = 2;
        end
      end else if (m_st == 2) begin
        if (p) m_st = 1;
      end
      m_busy = (m_st != 0);
    end
  endtask

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit p);
    exp_t e;
    rst = r; start = s; pause = p;
    model_step(r, s, p);
    e.num = 3'(m_num); e.rc = 3'(m_rc); e.row = m_row;
    e.busy = m_busy; e.done = m_done;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0; pause = 1'b0;
    e = sb.pop_front();
    checks++;
    if (num !== e.num || row_count !== e.rc || row !== e.row ||
        busy !== e.busy || done !== e.done) begin
      failures++;
      $display("FAIL sb t=%0t actual n=%0d rc=%0d row=%h b=%b d=%b required n=%0d rc=%0d row=%h b=%b d=%b",
               $time, num, row_count, row, busy, done,
               e.num, e.rc, e.row, e.busy, e.done);
    end
  endtask

  task automatic v(input bit r, input bit s, input bit p, input int idle,
                   input logic [2:0] n, input logic b, input logic d);
    vec_t x;
    x.r = r; x.s = s; x.p = p; x.idle = idle;
    x.num = n; x.busy = b; x.done = d;
    vt.push_back(x);
  endtask

  initial begin
    logic [7:0] one;
    logic [7:0] exp_row;
    one = 8'h01;

    // countdown, done, then idle
    v(0,1,0, 0, 5,1,0); v(0,0,0, 9, 4,1,0); v(0,0,0, 9, 3,1,0);
    v(0,0,0, 9, 2,1,0); v(0,0,0, 9, 1,1,0); v(0,0,0, 9, 0,0,1);
    v(0,0,0, 0, 0,0,0);
    // pause / resume resumes held tick
    v(0,1,0, 0, 5,1,0); v(0,0,0, 1, 5,1,0); v(0,0,1, 0, 5,1,0);
    v(0,0,0,19, 5,1,0); v(0,0,1, 0, 5,1,0); v(0,0,0, 5, 5,1,0);
    v(0,0,0, 0, 4,1,0);
    // tick terminal with pause
    v(0,0,0, 8, 4,1,0); v(0,0,1, 0, 3,1,0); v(0,0,0,15, 3,1,0);
    v(0,0,1, 0, 3,1,0); v(0,0,0, 9, 2,1,0);
    // restart in COUNT at num=2
    v(0,0,0, 4, 2,1,0); v(0,1,0, 0, 5,1,0); v(0,0,0, 8, 5,1,0);
    v(0,0,0, 0, 4,1,0);
    // tick terminal with start, then start+pause in COUNT
    v(0,0,0, 8, 4,1,0); v(0,1,0, 0, 5,1,0); v(0,0,0, 2, 5,1,0);
    v(0,1,1, 0, 5,1,0); v(0,0,0, 8, 5,1,0); v(0,0,0, 0, 4,1,0);
    // tick terminal with pause at num=1 goes idle with done
    v(0,0,0, 9, 3,1,0); v(0,0,0, 9, 2,1,0); v(0,0,0, 9, 1,1,0);
    v(0,0,0, 8, 1,1,0); v(0,0,1, 0, 0,0,1); v(0,0,0, 3, 0,0,0);
    v(0,0,1, 0, 0,0,0);
    // start+pause in IDLE
    v(0,1,1, 0, 5,1,0); v(0,0,0, 8, 5,1,0); v(0,0,0, 0, 4,1,0);
    // reset mid-count at num=3
    v(0,0,0, 9, 3,1,0); v(0,0,0, 3, 3,1,0); v(1,0,0, 0, 0,0,0);

    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0);
      check("rst_row", row, 8'hFF);
      check("rst_num", 8'(num), 8'd0);
      check("rst_busy", 8'(busy), 8'd0);
    end
    for (int k = 1; k <= 18; k++) begin
      cyc(0, 0, 0);
      exp_row = ~(one << (((k - 1) / 2) % 8));
      check($sformatf("scan_rc%0d", k), 8'(row_count),
            8'((k / 2) % 8));
      check($sformatf("scan_row%0d", k), row, exp_row);
    end

    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].r, vt[i].s, vt[i].p);
      for (int j = 0; j < vt[i].idle; j++) cyc(0, 0, 0);
      check($sformatf("vec%0d_num", i), 8'(num), 8'(vt[i].num));
      check($sformatf("vec%0d_busy", i), 8'(busy), 8'(vt[i].busy));
      check($sformatf("vec%0d_done", i), 8'(done), 8'(vt[i].done));
    end

    check("mid_rst_row", row, 8'hFF);
    check("mid_rst_rc", 8'(row_count), 8'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0);
      check($sformatf("post_rst_done%0d", i), 8'(done), 8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
